// File: rtl/sprite_pkg.sv
// Shared types and sizes for the sprite RAM arbiter and its round-robin picker.
package sprite_pkg;

   localparam int unsigned SPRITE_W     = 26;
   localparam int unsigned SPRITE_H     = 26;
   localparam int unsigned SPRITE_DEPTH = SPRITE_W * SPRITE_H;
   localparam int unsigned AW           = 10;
   localparam int unsigned DW           = 24;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2
   } arb_state_t;

   typedef logic [DW-1:0] texel_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   logic [PW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = PW'((32'(ptr) + k) % N);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Round-robin read arbiter and bulk-reload sequencer for the shared sprite RAM.
// Optional colour-key flag on responses when SPRITE_TRANSP_EN is defined.
module sprite_ram_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DEPTH = sprite_pkg::SPRITE_DEPTH,
   parameter int unsigned AW    = sprite_pkg::AW,
   parameter int unsigned DW    = sprite_pkg::DW
`ifdef SPRITE_TRANSP_EN
   ,
   parameter logic [DW-1:0] TKEY = DW'(24'hFF00FF)
`endif
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    gnt,
   output logic               rsp_valid,
   output logic [2:0]         rsp_id,
   output logic [DW-1:0]      rsp_data,
   output logic               rsp_err,
`ifdef SPRITE_TRANSP_EN
   output logic               rsp_transp,
`endif
   input  logic               load_start,
   input  logic               wr_valid,
   input  logic [DW-1:0]      wr_data,
   output logic               load_busy,
   output logic               load_done,
   output logic               ram_we,
   output logic [AW-1:0]      ram_write_address,
   output logic [AW-1:0]      ram_read_address,
   output logic [DW-1:0]      ram_data_In,
   input  logic [DW-1:0]      ram_data_Out
);

   localparam int unsigned PW = $clog2(NREQ);

   sprite_pkg::arb_state_t state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0] load_cnt_q, load_cnt_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [2:0]    rsp_id_q, rsp_id_d;
   logic          rsp_err_q, rsp_err_d;
   logic          load_busy_q, load_busy_d;
   logic          load_done_q, load_done_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_waddr_q, ram_waddr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;

   logic [NREQ-1:0] pick_gnt;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            grant_c;
   logic            addr_ok_c;
   logic [AW-1:0]   gnt_addr_c;

   rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Reads only in RUN; a load request in the same cycle takes priority.
   // Reset_n gates the grant so the read side is quiet while reset is held.
   always_comb begin
      grant_c    = Reset_n && (state_q == sprite_pkg::RUN) && !load_start && pick_any;
      gnt_addr_c = req_addr[32'(pick_idx)*AW +: AW];
      addr_ok_c  = 32'(gnt_addr_c) < DEPTH;
   end

   assign gnt              = grant_c ? pick_gnt : '0;
   assign ram_read_address = (grant_c && addr_ok_c) ? gnt_addr_c : '0;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      load_cnt_d  = load_cnt_q;
      rsp_valid_d = grant_c;
      rsp_id_d    = grant_c ? 3'(pick_idx) : 3'd0;
      rsp_err_d   = grant_c && !addr_ok_c;
      load_done_d = 1'b0;
      ram_we_d    = 1'b0;
      ram_waddr_d = ram_waddr_q;
      ram_wdata_d = ram_wdata_q;
      case (state_q)
         sprite_pkg::RUN: begin
            if (load_start) begin
               state_d = sprite_pkg::DRAIN;
            end else if (grant_c) begin
               rr_ptr_d = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
            end
         end
         sprite_pkg::DRAIN: begin
            state_d = sprite_pkg::LOAD;
         end
         sprite_pkg::LOAD: begin
            // Counter only advances on accepted texels, so the source may stall.
            if (wr_valid) begin
               ram_we_d    = 1'b1;
               ram_waddr_d = load_cnt_q;
               ram_wdata_d = wr_data;
               if (32'(load_cnt_q) == DEPTH - 1) begin
                  load_cnt_d  = '0;
                  load_done_d = 1'b1;
                  state_d     = sprite_pkg::RUN;
               end else begin
                  load_cnt_d = load_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = sprite_pkg::RUN;
         end
      endcase
      load_busy_d = (state_d != sprite_pkg::RUN);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= sprite_pkg::RUN;
         rr_ptr_q    <= '0;
         load_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
         load_busy_q <= 1'b0;
         load_done_q <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_waddr_q <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         load_cnt_q  <= load_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
         load_busy_q <= load_busy_d;
         load_done_q <= load_done_d;
         ram_we_q    <= ram_we_d;
         ram_waddr_q <= ram_waddr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   // RAM output register supplies the data stage; errored reads are forced to zero.
   assign rsp_data = (rsp_valid_q && !rsp_err_q) ? ram_data_Out : '0;
`ifdef SPRITE_TRANSP_EN
   assign rsp_transp = rsp_valid_q && !rsp_err_q && (ram_data_Out == TKEY);
`endif

   assign rsp_valid         = rsp_valid_q;
   assign rsp_id            = rsp_id_q;
   assign rsp_err           = rsp_err_q;
   assign load_busy         = load_busy_q;
   assign load_done         = load_done_q;
   assign ram_we            = ram_we_q;
   assign ram_write_address = ram_waddr_q;
   assign ram_data_In       = ram_wdata_q;

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Directed bench for sprite_ram_arbiter with a behavioural registered-output sprite RAM.
module tb_sprite_ram_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 24;
   localparam int unsigned DEPTH = 676;

   logic               Clk;
   logic               Reset_n;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    gnt;
   logic               rsp_valid;
   logic [2:0]         rsp_id;
   logic [DW-1:0]      rsp_data;
   logic               rsp_err;
`ifdef SPRITE_TRANSP_EN
   logic               rsp_transp;
`endif
   logic               load_start;
   logic               wr_valid;
   logic [DW-1:0]      wr_data;
   logic               load_busy;
   logic               load_done;
   logic               ram_we;
   logic [AW-1:0]      ram_write_address;
   logic [AW-1:0]      ram_read_address;
   logic [DW-1:0]      ram_data_In;
   logic [DW-1:0]      ram_data_Out;

   logic [DW-1:0] mem [0:1023];

   int total = 0;
   int bad   = 0;
   int k, pk, lerr, merr, guard;
   logic v, pv;

   sprite_ram_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .req               (req),
      .req_addr          (req_addr),
      .gnt               (gnt),
      .rsp_valid         (rsp_valid),
      .rsp_id            (rsp_id),
      .rsp_data          (rsp_data),
      .rsp_err           (rsp_err),
`ifdef SPRITE_TRANSP_EN
      .rsp_transp        (rsp_transp),
`endif
      .load_start        (load_start),
      .wr_valid          (wr_valid),
      .wr_data           (wr_data),
      .load_busy         (load_busy),
      .load_done         (load_done),
      .ram_we            (ram_we),
      .ram_write_address (ram_write_address),
      .ram_read_address  (ram_read_address),
      .ram_data_In       (ram_data_In),
      .ram_data_Out      (ram_data_Out)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Sprite RAM: synchronous write, registered read (one-cycle latency).
   always @(posedge Clk) begin
      if (ram_we) mem[ram_write_address] <= ram_data_In;
      ram_data_Out <= mem[ram_read_address];
   end

   function automatic logic [DW-1:0] rr_val(input int i);
      return 24'h300000 + 24'(i) * 24'h010101;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {gnt, rsp_valid, rsp_id, rsp_err, load_busy, load_done, ram_we}, '0);
      chk({tag, "_dat"}, {rsp_data, ram_data_In}, '0);
      chk({tag, "_adr"}, {ram_write_address, ram_read_address}, '0);
`ifdef SPRITE_TRANSP_EN
      chk({tag, "_tr"}, rsp_transp, '0);
`endif
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0; req = '0; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[0]   = 24'hFF00FF;
      mem[5]   = 24'h2121DE;
      mem[10]  = 24'hFF00FF;
      mem[11]  = 24'hFF00FE;
      mem[675] = 24'h123456;
      for (int i = 0; i < 4; i++) mem[20 + i] = rr_val(i);
      ram_data_Out = '0;

      // Reset, with requests held to show the read side stays quiet
      Reset_n = 1'b0; req = 4'hF; req_addr = '0; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk); #1;
      chk_zero("reset");
      req = '0;
      Reset_n = 1'b1;

      // Single requester
      @(negedge Clk); req = 4'b0100; req_addr[2*AW +: AW] = 10'd5; #1;
      chk("single_gnt", gnt, 4'b0100);
      chk("single_raddr", ram_read_address, 10'd5);
      @(negedge Clk); req = '0; #1;
      chk("single_valid", rsp_valid, 1'b1);
      chk("single_id", rsp_id, 3'd2);
      chk("single_data", rsp_data, 24'h2121DE);
      chk("single_err", rsp_err, 1'b0);
      chk("single_gnt_off", gnt, 4'b0000);
      @(negedge Clk); #1;
      chk("single_idle", rsp_valid, 1'b0);

      // All four requesting, pointer from 0
      do_reset();
      for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 10'(20 + i);
      for (int c = 0; c < 8; c++) begin
         @(negedge Clk); req = 4'hF; #1;
         chk($sformatf("rr_gnt%0d", c), gnt, 4'b0001 << (c % 4));
         if (c > 0) begin
            chk($sformatf("rr_valid%0d", c), rsp_valid, 1'b1);
            chk($sformatf("rr_id%0d", c), rsp_id, 3'((c - 1) % 4));
            chk($sformatf("rr_data%0d", c), rsp_data, rr_val((c - 1) % 4));
         end
      end
      @(negedge Clk); req = '0; #1;
      chk("rr_last_id", rsp_id, 3'd3);
      chk("rr_last_data", rsp_data, rr_val(3));
      chk("rr_gnt_off", gnt, 4'b0000);

      // Out-of-range address: still granted, RAM address 0, data forced 0
      @(negedge Clk); req = 4'b0010; req_addr[1*AW +: AW] = 10'd676; #1;
      chk("oor_gnt", gnt, 4'b0010);
      chk("oor_raddr", ram_read_address, 10'd0);
      @(negedge Clk); req_addr[1*AW +: AW] = 10'd675; #1;
      chk("oor_valid", rsp_valid, 1'b1);
      chk("oor_id", rsp_id, 3'd1);
      chk("oor_err", rsp_err, 1'b1);
      chk("oor_data", rsp_data, 24'h0);
      chk("top_gnt", gnt, 4'b0010);
      chk("top_raddr", ram_read_address, 10'd675);
      @(negedge Clk); req = '0; #1;
      chk("top_err", rsp_err, 1'b0);
      chk("top_data", rsp_data, 24'h123456);

      // Pointer wrap and hold across idle cycles (pointer is 2 here)
      @(negedge Clk); req = 4'b0101; #1;
      chk("wrap_a", gnt, 4'b0100);
      @(negedge Clk); #1;
      chk("wrap_b", gnt, 4'b0001);
      @(negedge Clk); req = '0; #1;
      chk("idle_gnt", gnt, 4'b0000);
      @(negedge Clk); #1;
      @(negedge Clk); req = 4'b1001; #1;
      chk("hold_ptr", gnt, 4'b1000);
      @(negedge Clk); req = '0; #1;

`ifdef SPRITE_TRANSP_EN
      @(negedge Clk); req = 4'b0001; req_addr[0 +: AW] = 10'd10; #1;
      @(negedge Clk); req_addr[0 +: AW] = 10'd11; #1;
      chk("tr_key", rsp_transp, 1'b1);
      chk("tr_key_data", rsp_data, 24'hFF00FF);
      @(negedge Clk); req = 4'b0010; req_addr[1*AW +: AW] = 10'd676; #1;
      chk("tr_near", rsp_transp, 1'b0);
      @(negedge Clk); req = '0; #1;
      chk("tr_oor_err", rsp_err, 1'b1);
      chk("tr_oor", rsp_transp, 1'b0);
`endif

      // Bulk load while requester 0 streams
      @(negedge Clk); req = 4'b0001; req_addr[0 +: AW] = 10'd5; #1;
      chk("ld_pre_gnt", gnt, 4'b0001);
      @(negedge Clk); load_start = 1'b1; #1;
      chk("ld_start_gnt", gnt, 4'b0000);
      chk("ld_inflight_valid", rsp_valid, 1'b1);
      chk("ld_inflight_id", rsp_id, 3'd0);
      chk("ld_inflight_data", rsp_data, 24'h2121DE);
      chk("ld_start_busy", load_busy, 1'b0);
      @(negedge Clk); load_start = 1'b0; #1;
      chk("drain_busy", load_busy, 1'b1);
      chk("drain_gnt", gnt, 4'b0000);
      chk("drain_valid", rsp_valid, 1'b0);
      @(negedge Clk); load_start = 1'b1; #1;
      chk("load1_busy", load_busy, 1'b1);
      chk("load1_gnt", gnt, 4'b0000);
      load_start = 1'b0;

      k = 0; pk = 0; pv = 1'b0; lerr = 0; guard = 0;
      while (k < int'(DEPTH) && guard < 10000) begin
         @(negedge Clk);
         v = ($urandom_range(0, 3) != 0);
         wr_valid = v; wr_data = 24'(k);
         #1;
         if (ram_we !== pv || gnt !== 4'b0000 || load_done !== 1'b0 || load_busy !== 1'b1) lerr++;
         if (pv && (ram_write_address !== 10'(pk) || ram_data_In !== 24'(pk))) lerr++;
         pv = v; pk = k;
         if (v) k++;
         guard++;
      end
      chk("ld_beats", k, DEPTH);
      chk("ld_seq_err", lerr, 0);
      @(negedge Clk); wr_valid = 1'b0; #1;
      chk("ld_last_we", ram_we, 1'b1);
      chk("ld_last_addr", ram_write_address, 10'd675);
      chk("ld_last_data", ram_data_In, 24'd675);
      chk("ld_done", load_done, 1'b1);
      chk("ld_busy_drop", load_busy, 1'b0);
      chk("ld_resume_gnt", gnt, 4'b0001);
      @(negedge Clk); req = '0; #1;
      chk("ld_done_pulse", load_done, 1'b0);
      chk("ld_resume_valid", rsp_valid, 1'b1);
      chk("ld_resume_data", rsp_data, 24'd5);
      merr = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== 24'(i)) merr++;
      chk("ld_image", merr, 0);

      // Reset part-way through a load
      @(negedge Clk); load_start = 1'b1; #1;
      @(negedge Clk); load_start = 1'b0; #1;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk); wr_valid = 1'b1; wr_data = 24'hAA0000 + 24'(i);
      end
      @(negedge Clk); req = 4'b1000; #1;
      chk("mid_we", ram_we, 1'b1);
      chk("mid_addr", ram_write_address, 10'd99);
      Reset_n = 1'b0; #1;
      chk_zero("mid_rst");
      @(negedge Clk); Reset_n = 1'b1; wr_valid = 1'b0; req = 4'b1001; #1;
      chk("post_rst_gnt", gnt, 4'b0001);
      chk("post_rst_busy", load_busy, 1'b0);
      @(negedge Clk); req = '0; #1;
      chk("post_rst_done_a", load_done, 1'b0);
      @(negedge Clk); load_start = 1'b1; #1;
      chk("post_rst_done_b", load_done, 1'b0);
      @(negedge Clk); load_start = 1'b0; #1;
      @(negedge Clk); wr_valid = 1'b1; wr_data = 24'h000055; #1;
      @(negedge Clk); wr_valid = 1'b0; #1;
      chk("post_rst_cnt_we", ram_we, 1'b1);
      chk("post_rst_cnt", ram_write_address, 10'd0);
      chk("post_rst_done_c", load_done, 1'b0);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
